// File: rtl/crc_fcs_insert_if.sv
// Byte-stream bus around the FCS inserter: upstream "pre" side and downstream "post" side.
interface crc_fcs_insert_if;
    logic [7:0] i_pre_data;
    logic       i_pre_valid;
    logic       i_pre_last;
    logic       o_pre_ready;
    logic [7:0] o_post_data;
    logic       o_post_valid;
    logic       o_post_last;

    // slave is the inserter itself; master is the frame source / sink around it.
    modport slave (
        input  i_pre_data, i_pre_valid, i_pre_last,
        output o_pre_ready, o_post_data, o_post_valid, o_post_last
    );
    modport master (
        output i_pre_data, i_pre_valid, i_pre_last,
        input  o_pre_ready, o_post_data, o_post_valid, o_post_last
    );
endinterface

// File: rtl/crc_fcs_insert.sv
// Transmit-side framer: forwards payload, zero-pads short frames to the minimum length,
// and appends the Ethernet FCS (reflected CRC-32), stalling upstream while it does so.
module crc_fcs_insert #(
    parameter int P_MIN_LEN = 60,
    parameter bit P_PAD_EN  = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    crc_fcs_insert_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [10:0] MIN_LEN  = 11'(P_MIN_LEN);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    state_t      state, state_next;
    logic [31:0] crc, crc_next, fcs_word;
    logic [10:0] count, count_next, count_inc;
    logic [1:0]  fcs_idx, fcs_idx_next;
    logic [7:0]  data_q, data_next;
    logic        valid_q, valid_next;
    logic        last_q, last_next;
    logic        ready_q, ready_next;
    logic        accept, want_pad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    assign accept    = bus.i_pre_valid && ready_q;
    assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
    assign want_pad  = P_PAD_EN && (count_inc < MIN_LEN);
    assign fcs_word  = ~crc;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_next   = state;
        crc_next     = crc;
        count_next   = count;
        fcs_idx_next = fcs_idx;
        data_next    = 8'h00;
        valid_next   = 1'b0;
        last_next    = 1'b0;

        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    data_next  = bus.i_pre_data;
                    valid_next = 1'b1;
                    crc_next   = crc_byte(crc, bus.i_pre_data);
                    count_next = count_inc;
                    if (bus.i_pre_last) state_next = want_pad ? PAD : FCS;
                    else                state_next = DATA;
                end
            end
            PAD: begin
                valid_next = 1'b1;
                crc_next   = crc_byte(crc, 8'h00);
                count_next = count_inc;
                if (count_inc >= MIN_LEN) state_next = FCS;
            end
            FCS: begin
                valid_next   = 1'b1;
                data_next    = fcs_word[{fcs_idx, 3'b000} +: 8];
                fcs_idx_next = fcs_idx + 2'd1;
                if (fcs_idx == 2'd3) begin
                    last_next  = 1'b1;
                    state_next = IDLE;
                    crc_next   = CRC_INIT;
                    count_next = 11'd0;
                end
            end
            default: state_next = IDLE;
        endcase

        // NOTE: ready is registered from the next state, so it drops the cycle after the last accept.
        ready_next = (state_next == IDLE) || (state_next == DATA);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            crc     <= CRC_INIT;
            count   <= 11'd0;
            fcs_idx <= 2'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            crc     <= crc_next;
            count   <= count_next;
            fcs_idx <= fcs_idx_next;
            data_q  <= data_next;
            valid_q <= valid_next;
            last_q  <= last_next;
            ready_q <= ready_next;
        end
    end

    assign bus.o_pre_ready  = ready_q;
    assign bus.o_post_data  = data_q;
    assign bus.o_post_valid = valid_q;
    assign bus.o_post_last  = last_q;
endmodule

// File: tb/tb_crc_fcs_insert.sv
// Directed bench for crc_fcs_insert: one padded and one unpadded instance, output streams
// captured per cycle and compared against a table-driven CRC-32 reference and fixed timing.
module tb_crc_fcs_insert;
    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       l;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_fcs_insert_if ifp ();
    crc_fcs_insert_if ifn ();

    crc_fcs_insert #(.P_MIN_LEN(60), .P_PAD_EN(1'b1)) dut_pad   (.i_clk(clk), .i_rst(rst), .bus(ifp));
    crc_fcs_insert #(.P_MIN_LEN(60), .P_PAD_EN(1'b0)) dut_nopad (.i_clk(clk), .i_rst(rst), .bus(ifn));

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    obs_t        obs_p[$];
    obs_t        obs_n[$];
    int          rl_p = 0;
    int          rl_n = 0;
    int          orphan = 0;
    logic [7:0]  tx_d[$];
    bit          tx_l[$];
    int          acc_q[$];
    logic [7:0]  fr_q[$];
    logic [8:0]  exp_q[$];
    logic [31:0] crc_tab[256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ifp.o_post_valid) obs_p.push_back('{cyc, ifp.o_post_data, ifp.o_post_last});
            if (ifn.o_post_valid) obs_n.push_back('{cyc, ifn.o_post_data, ifn.o_post_last});
            if (!ifp.o_pre_ready) rl_p++;
            if (!ifn.o_pre_ready) rl_n++;
            if (ifp.o_post_last && !ifp.o_post_valid) orphan++;
            if (ifn.o_post_last && !ifn.o_post_valid) orphan++;
        end
    end

    task automatic set_in(input bit to_pad, input bit v, input logic [7:0] d, input bit l);
        if (to_pad) begin
            ifp.i_pre_valid = v; ifp.i_pre_data = d; ifp.i_pre_last = l;
        end else begin
            ifn.i_pre_valid = v; ifn.i_pre_data = d; ifn.i_pre_last = l;
        end
    endtask

    // Upstream source: holds the current byte while ready is low, optional random gaps.
    task automatic drive(input bit to_pad, input int gap_pct);
        int i = 0;
        int guard = 0;
        bit rdy, v;
        acc_q.delete();
        while (i < tx_d.size() && guard < 5000) begin
            rdy = to_pad ? ifp.o_pre_ready : ifn.o_pre_ready;
            v = !(rdy && gap_pct > 0 && $urandom_range(99) < gap_pct);
            if (v) set_in(to_pad, 1'b1, tx_d[i], tx_l[i]);
            else   set_in(to_pad, 1'b0, 8'h00, 1'b0);
            if (v && rdy) acc_q.push_back(cyc);
            @(posedge clk);
            #1;
            if (v && rdy) i++;
            guard++;
        end
        set_in(to_pad, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (i != tx_d.size()) begin
            $display("FAIL drive_timeout: accepted %0d bytes, needed %0d", i, tx_d.size());
            n_err++;
        end
        tx_d.delete();
        tx_l.delete();
    endtask

    task automatic wait_out(input bit to_pad, input int n);
        int t = 0;
        while ((to_pad ? obs_p.size() : obs_n.size()) < n && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if ((to_pad ? obs_p.size() : obs_n.size()) < n) begin
            $display("FAIL wait_out_timeout: got %0d bytes, needed %0d",
                     to_pad ? obs_p.size() : obs_n.size(), n);
            n_err++;
        end
    endtask

    // Reference frame: payload, optional zero pad to 60, then ~CRC low byte first.
    task automatic add_exp(input bit pad_en);
        logic [31:0] c;
        int n;
        c = 32'hFFFF_FFFF;
        n = fr_q.size();
        for (int i = 0; i < fr_q.size(); i++) begin
            exp_q.push_back({1'b0, fr_q[i]});
            c = crc_tab[c[7:0] ^ fr_q[i]] ^ (c >> 8);
        end
        while (pad_en && n < 60) begin
            exp_q.push_back(9'h000);
            c = crc_tab[c[7:0]] ^ (c >> 8);
            n++;
        end
        c = ~c;
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b1, c[31:24]});
        for (int i = 0; i < fr_q.size(); i++) begin
            tx_d.push_back(fr_q[i]);
            tx_l.push_back(i == fr_q.size() - 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ifp.o_pre_ready, ifp.o_post_data, ifp.o_post_valid, ifp.o_post_last} !== 11'b1_00000000_0_0) begin
            $display("FAIL reset_pad: rdy/data/vld/last got %b %h %b %b, want 1 00 0 0",
                     ifp.o_pre_ready, ifp.o_post_data, ifp.o_post_valid, ifp.o_post_last);
            n_err++;
        end
        n_vec++;
        if ({ifn.o_pre_ready, ifn.o_post_data, ifn.o_post_valid, ifn.o_post_last} !== 11'b1_00000000_0_0) begin
            $display("FAIL reset_nopad: rdy/data/vld/last got %b %h %b %b, want 1 00 0 0",
                     ifn.o_pre_ready, ifn.o_post_data, ifn.o_post_valid, ifn.o_post_last);
            n_err++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nopad_check;
        logic [7:0] ref_b[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                  8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 9; i++) begin
            tx_d.push_back(8'(8'h31 + i));
            tx_l.push_back(i == 8);
        end
        obs_n.delete();
        rl_n = 0;
        drive(1'b0, 0);
        wait_out(1'b0, 13);
        n_vec++;
        if (obs_n.size() != 13) begin
            $display("FAIL nopad_len: got %0d bytes, want 13", obs_n.size()); n_err++;
        end
        for (int i = 0; i < 13 && i < obs_n.size(); i++) begin
            n_vec++;
            if ({obs_n[i].l, obs_n[i].d} !== {(i == 12), ref_b[i]}) begin
                $display("FAIL nopad_byte[%0d]: got last=%b %h, want last=%b %h",
                         i, obs_n[i].l, obs_n[i].d, (i == 12), ref_b[i]);
                n_err++;
            end
        end
        n_vec++;
        if (obs_n.size() == 13 && acc_q.size() == 9 && obs_n[12].cyc - acc_q[8] != 5) begin
            $display("FAIL nopad_last_latency: got %0d cycles, want 5", obs_n[12].cyc - acc_q[8]); n_err++;
        end
        n_vec++;
        if (rl_n != 4) begin
            $display("FAIL nopad_ready_low: got %0d cycles, want 4", rl_n); n_err++;
        end
    endtask

    task automatic test_pad_short;
        fr_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) fr_q.push_back(8'(8'h31 + i));
        add_exp(1'b1);
        obs_p.delete();
        rl_p = 0;
        drive(1'b1, 0);
        wait_out(1'b1, 64);
        n_vec++;
        if (obs_p.size() != 64) begin
            $display("FAIL pad9_len: got %0d bytes, want 64", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL pad9_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
        n_vec++;
        if (rl_p != 55) begin
            $display("FAIL pad9_ready_low: got %0d cycles, want 55", rl_p); n_err++;
        end
        n_vec++;
        if (obs_p.size() == 64 && obs_p[63].cyc - acc_q[8] != 56) begin
            $display("FAIL pad9_last_latency: got %0d cycles, want 56", obs_p[63].cyc - acc_q[8]); n_err++;
        end
    endtask

    task automatic test_random_gaps;
        fr_q.delete(); exp_q.delete();
        for (int i = 0; i < 100; i++) fr_q.push_back(8'($urandom_range(255)));
        add_exp(1'b1);
        obs_p.delete();
        drive(1'b1, 30);
        wait_out(1'b1, 104);
        n_vec++;
        if (obs_p.size() != 104) begin
            $display("FAIL gaps_len: got %0d bytes, want 104", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL gaps_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
        for (int i = 0; i < 100 && i < obs_p.size() && i < acc_q.size(); i++) begin
            n_vec++;
            if (obs_p[i].cyc != acc_q[i] + 1) begin
                $display("FAIL gaps_timing[%0d]: out cycle %0d, want %0d", i, obs_p[i].cyc, acc_q[i] + 1); n_err++;
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            fr_q.delete();
            for (int i = 0; i < 60; i++) fr_q.push_back(8'($urandom_range(255)));
            add_exp(1'b1);
        end
        obs_p.delete();
        drive(1'b1, 0);
        wait_out(1'b1, 128);
        n_vec++;
        if (obs_p.size() != 128) begin
            $display("FAIL b2b_len: got %0d bytes, want 128", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL b2b_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
        n_vec++;
        if (obs_p.size() == 128 && obs_p[127].cyc - obs_p[0].cyc != 127) begin
            $display("FAIL b2b_idle_gap: span %0d cycles, want 127", obs_p[127].cyc - obs_p[0].cyc); n_err++;
        end
    endtask

    task automatic test_reset_mid;
        int n_last = 0;
        fr_q.delete(); exp_q.delete();
        for (int i = 0; i < 64; i++) fr_q.push_back(8'($urandom_range(1, 255)));
        for (int i = 0; i < 20; i++) begin
            tx_d.push_back(fr_q[i]);
            tx_l.push_back(1'b0);
        end
        obs_p.delete();
        drive(1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ifp.o_pre_ready, ifp.o_post_data, ifp.o_post_valid, ifp.o_post_last} !== 11'b1_00000000_0_0) begin
            $display("FAIL midrst_outputs: rdy/data/vld/last got %b %h %b %b, want 1 00 0 0",
                     ifp.o_pre_ready, ifp.o_post_data, ifp.o_post_valid, ifp.o_post_last);
            n_err++;
        end
        foreach (obs_p[i]) if (obs_p[i].l) n_last++;
        n_vec++;
        if (n_last != 0) begin
            $display("FAIL midrst_no_last: got %0d last pulses, want 0", n_last); n_err++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        add_exp(1'b1);
        obs_p.delete();
        drive(1'b1, 0);
        wait_out(1'b1, 68);
        n_vec++;
        if (obs_p.size() != 68) begin
            $display("FAIL midrst_len: got %0d bytes, want 68", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL midrst_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
    endtask

    task automatic test_min_boundary;
        fr_q.delete(); exp_q.delete();
        for (int i = 0; i < 59; i++) fr_q.push_back(8'($urandom_range(1, 255)));
        add_exp(1'b1);
        obs_p.delete();
        rl_p = 0;
        drive(1'b1, 0);
        wait_out(1'b1, 64);
        n_vec++;
        if (obs_p.size() != 64) begin
            $display("FAIL len59_len: got %0d bytes, want 64", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL len59_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
        n_vec++;
        if (rl_p != 5) begin
            $display("FAIL len59_ready_low: got %0d cycles, want 5", rl_p); n_err++;
        end
    endtask

    task automatic test_single_zero;
        fr_q.delete(); exp_q.delete();
        fr_q.push_back(8'h00);
        add_exp(1'b1);
        obs_p.delete();
        rl_p = 0;
        drive(1'b1, 0);
        wait_out(1'b1, 64);
        n_vec++;
        if (obs_p.size() != 64) begin
            $display("FAIL zero1_len: got %0d bytes, want 64", obs_p.size()); n_err++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_p.size(); i++) begin
            n_vec++;
            if ({obs_p[i].l, obs_p[i].d} !== exp_q[i]) begin
                $display("FAIL zero1_byte[%0d]: got %h, want %h", i, {obs_p[i].l, obs_p[i].d}, exp_q[i]); n_err++;
            end
        end
        n_vec++;
        if (rl_p != 63) begin
            $display("FAIL zero1_ready_low: got %0d cycles, want 63", rl_p); n_err++;
        end
        n_vec++;
        if (orphan != 0) begin
            $display("FAIL last_without_valid: got %0d cycles, want 0", orphan); n_err++;
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        test_reset;
        test_nopad_check;
        test_pad_short;
        test_random_gaps;
        test_back_to_back;
        test_reset_mid;
        test_min_boundary;
        test_single_zero;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 2 ms");
        $fatal(1, "timeout");
    end
endmodule
